// File: rtl/mdio_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_arbiter
// Two-port round-robin arbiter and transaction sequencer in front of the MDIO
// management generator. Accepts 32-bit Clause-22 frames from two requesters,
// validates them, launches one at a time on the generator and returns read
// data, write completion or an error to the requester that owns the transfer.
//
// Ports
//   clk, reset              : system clock, synchronous active-high reset
//   REQ0/REQ1, REQn_DATA    : request + frame, held until the matching ACKn
//   ACK0/ACK1               : one-cycle accept pulse
//   RSPn_VALID/DATA/ERR     : one-cycle completion pulse, data and error flag
//   MDIO_START, T_DATA      : launch strobe and frame to the generator
//   MDC                     : generator management clock (rise counting)
//   DATA_RDY, RD_DATA       : read completion and read data from the generator
//   BUSY                    : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mdio_arbiter #(
   parameter int unsigned TIMEOUT = 2048
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [31:0] REQ0_DATA,
   input  logic [31:0] REQ1_DATA,
   output logic        ACK0,
   output logic        ACK1,
   output logic        RSP0_VALID,
   output logic        RSP1_VALID,
   output logic [15:0] RSP0_DATA,
   output logic [15:0] RSP1_DATA,
   output logic        RSP0_ERR,
   output logic        RSP1_ERR,
   output logic        MDIO_START,
   output logic [31:0] T_DATA,
   input  logic        MDC,
   input  logic        DATA_RDY,
   input  logic [15:0] RD_DATA,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_RESP = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 32'd1);
   localparam logic [5:0]  RISE_DONE = 6'd32;

   // A frame is launchable only with ST=01 and OP=write(01) or read(10).
   function automatic logic frame_valid(input logic [31:0] frame);
      frame_valid = (frame[31:30] == 2'b01) &&
                    ((frame[29:28] == 2'b01) || (frame[29:28] == 2'b10));
   endfunction

   state_t      state_q, state_d;
   logic        owner_q, owner_d;       // 1: requester 1 owns the transfer
   logic        prio1_q, prio1_d;       // 1: requester 1 wins the next tie
   logic        is_read_q, is_read_d;
   logic        pend_q, pend_d;         // malformed frame, error response still owed
   logic        mdc_q;
   logic [5:0]  rise_cnt_q, rise_cnt_d;
   logic [15:0] cyc_cnt_q, cyc_cnt_d;

   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
   logic [15:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
   logic        rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
   logic        start_q, start_d;
   logic [31:0] t_data_q, t_data_d;
   logic        busy_q;

   logic        gnt_sel_s;
   logic [31:0] gnt_frame_s;
   logic        mdc_rise_s;
   logic [5:0]  rise_next_s;
   logic        done_s;
   logic        rsp_fire_s;
   logic        rsp_err_s;
   logic [15:0] rsp_data_s;

   // Grant selection and MDC rise counting with saturation at 32.
   always_comb begin
      if (REQ0 && REQ1) begin
         gnt_sel_s = prio1_q;
      end else begin
         gnt_sel_s = REQ1;
      end
      gnt_frame_s = gnt_sel_s ? REQ1_DATA : REQ0_DATA;
      mdc_rise_s  = MDC & ~mdc_q;
      if (rise_cnt_q == RISE_DONE) begin
         rise_next_s = RISE_DONE;
      end else if (mdc_rise_s) begin
         rise_next_s = rise_cnt_q + 6'd1;
      end else begin
         rise_next_s = rise_cnt_q;
      end
      // A read finishes only on DATA_RDY; 32 rises alone do not complete it.
      done_s = is_read_q ? DATA_RDY : (rise_next_s == RISE_DONE);
   end

   // Sequencer next state and registered-output next values.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      prio1_d    = prio1_q;
      is_read_d  = is_read_q;
      pend_d     = pend_q;
      rise_cnt_d = rise_cnt_q;
      cyc_cnt_d  = cyc_cnt_q;
      start_d    = start_q;
      t_data_d   = t_data_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      rsp_fire_s = 1'b0;
      rsp_err_s  = 1'b0;
      rsp_data_s = 16'h0000;

      case (state_q)
         S_IDLE: begin
            if (REQ0 || REQ1) begin
               owner_d    = gnt_sel_s;
               ack0_d     = ~gnt_sel_s;
               ack1_d     = gnt_sel_s;
               is_read_d  = (gnt_frame_s[29:28] == 2'b10);
               rise_cnt_d = 6'd0;
               cyc_cnt_d  = 16'd0;
               // The pointer only moves when both requesters compete.
               if (REQ0 && REQ1) begin
                  prio1_d = ~prio1_q;
               end else begin
                  prio1_d = prio1_q;
               end
               if (frame_valid(gnt_frame_s)) begin
                  t_data_d = gnt_frame_s;
                  start_d  = 1'b1;
                  pend_d   = 1'b0;
                  state_d  = S_RUN;
               end else begin
                  start_d  = 1'b0;
                  pend_d   = 1'b1;
                  state_d  = S_RESP;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            rise_cnt_d = rise_next_s;
            cyc_cnt_d  = cyc_cnt_q + 16'd1;
            // Completion is checked first so it wins over a same-cycle timeout.
            if (done_s) begin
               rsp_fire_s = 1'b1;
               rsp_data_s = is_read_q ? RD_DATA : 16'h0000;
               start_d    = 1'b0;
               state_d    = S_RESP;
            end else if (cyc_cnt_q == TO_LAST) begin
               rsp_fire_s = 1'b1;
               rsp_err_s  = 1'b1;
               rsp_data_s = 16'hFFFF;
               start_d    = 1'b0;
               state_d    = S_RESP;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RESP: begin
            start_d = 1'b0;
            // A malformed frame arrives here without having answered yet, so
            // it answers now and spends one more cycle in RESP.
            if (pend_q) begin
               rsp_fire_s = 1'b1;
               rsp_err_s  = 1'b1;
               rsp_data_s = 16'hFFFF;
               pend_d     = 1'b0;
               state_d    = S_RESP;
            end else begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            start_d = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            start_d = 1'b0;
            pend_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      rsp0_valid_d = rsp_fire_s & ~owner_q;
      rsp1_valid_d = rsp_fire_s & owner_q;
      rsp0_err_d   = rsp_fire_s & ~owner_q & rsp_err_s;
      rsp1_err_d   = rsp_fire_s & owner_q & rsp_err_s;
      rsp0_data_d  = (rsp_fire_s && !owner_q) ? rsp_data_s : 16'h0000;
      rsp1_data_d  = (rsp_fire_s && owner_q) ? rsp_data_s : 16'h0000;
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         prio1_q      <= 1'b0;
         is_read_q    <= 1'b0;
         pend_q       <= 1'b0;
         mdc_q        <= 1'b0;
         rise_cnt_q   <= 6'd0;
         cyc_cnt_q    <= 16'd0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= 16'h0000;
         rsp1_data_q  <= 16'h0000;
         rsp0_err_q   <= 1'b0;
         rsp1_err_q   <= 1'b0;
         start_q      <= 1'b0;
         t_data_q     <= 32'h0000_0000;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         prio1_q      <= prio1_d;
         is_read_q    <= is_read_d;
         pend_q       <= pend_d;
         mdc_q        <= MDC;
         rise_cnt_q   <= rise_cnt_d;
         cyc_cnt_q    <= cyc_cnt_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
         rsp0_err_q   <= rsp0_err_d;
         rsp1_err_q   <= rsp1_err_d;
         start_q      <= start_d;
         t_data_q     <= t_data_d;
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign ACK0       = ack0_q;
   assign ACK1       = ack1_q;
   assign RSP0_VALID = rsp0_valid_q;
   assign RSP1_VALID = rsp1_valid_q;
   assign RSP0_DATA  = rsp0_data_q;
   assign RSP1_DATA  = rsp1_data_q;
   assign RSP0_ERR   = rsp0_err_q;
   assign RSP1_ERR   = rsp1_err_q;
   assign MDIO_START = start_q;
   assign T_DATA     = t_data_q;
   assign BUSY       = busy_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mdio_arbiter
// Directed, table-driven bench for mdio_arbiter. A main instance with a long
// timeout runs the transaction table, contention and reset-mid-read sequences;
// a second instance with TIMEOUT=64 covers the timeout path.
// -----------------------------------------------------------------------------
module tb_mdio_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [31:0] req0_data, req1_data;
   logic        mdc, data_rdy;
   logic [15:0] rd_data;
   logic        ack0, ack1, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic [15:0] rsp0_data, rsp1_data;
   logic        mdio_start, busy;
   logic [31:0] t_data;

   logic        t_req0, t_req1, t_rdy;
   logic [31:0] t_req0_data, t_req1_data;
   logic        t_ack0, t_ack1, t_rsp0_valid, t_rsp1_valid, t_rsp0_err, t_rsp1_err;
   logic [15:0] t_rsp0_data, t_rsp1_data;
   logic        t_start, t_busy;
   logic [31:0] t_tdata;

   always #5 clk = ~clk;

   mdio_arbiter #(.TIMEOUT(512)) dut (
      .clk(clk), .reset(reset),
      .REQ0(req0), .REQ1(req1), .REQ0_DATA(req0_data), .REQ1_DATA(req1_data),
      .ACK0(ack0), .ACK1(ack1),
      .RSP0_VALID(rsp0_valid), .RSP1_VALID(rsp1_valid),
      .RSP0_DATA(rsp0_data), .RSP1_DATA(rsp1_data),
      .RSP0_ERR(rsp0_err), .RSP1_ERR(rsp1_err),
      .MDIO_START(mdio_start), .T_DATA(t_data),
      .MDC(mdc), .DATA_RDY(data_rdy), .RD_DATA(rd_data), .BUSY(busy)
   );

   mdio_arbiter #(.TIMEOUT(64)) dut_t (
      .clk(clk), .reset(reset),
      .REQ0(t_req0), .REQ1(t_req1), .REQ0_DATA(t_req0_data), .REQ1_DATA(t_req1_data),
      .ACK0(t_ack0), .ACK1(t_ack1),
      .RSP0_VALID(t_rsp0_valid), .RSP1_VALID(t_rsp1_valid),
      .RSP0_DATA(t_rsp0_data), .RSP1_DATA(t_rsp1_data),
      .RSP0_ERR(t_rsp0_err), .RSP1_ERR(t_rsp1_err),
      .MDIO_START(t_start), .T_DATA(t_tdata),
      .MDC(mdc), .DATA_RDY(t_rdy), .RD_DATA(rd_data), .BUSY(t_busy)
   );

   typedef struct {
      logic        r0;
      logic        r1;
      logic [31:0] d;
      logic        is_read;
      int          rdy_dly;    // cycles after ACK before DATA_RDY, -1 = never
      logic [15:0] rd;
      logic [1:0]  exp_ack;    // {ACK1, ACK0}
      logic        exp_start;
      logic        exp_err;
      logic [15:0] exp_data;
      int          exp_lat;    // edges from ACK to RSP, 0 = not fixed
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rises = 0;
   int   rises_seen = 0;
   int   mdc_div = 0;
   logic mdc_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One clock: outputs settle #1 after the edge; the model generator then
   // toggles MDC every 2 cycles. rises_seen = rises visible to the DUT at the edge.
   task automatic tick();
      rises_seen = rises;
      @(posedge clk);
      #1;
      cyc++;
      if (mdc_en) begin
         mdc_div++;
         if (mdc_div == 2) begin
            mdc_div = 0;
            mdc = ~mdc;
            if (mdc) rises++;
         end
      end else begin
         mdc_div = 0;
         mdc = 1'b0;
      end
   endtask

   task automatic wait_ack(output logic [1:0] who, output int at);
      who = 2'b00;
      at  = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ack0 | ack1) begin
            who = {ack1, ack0};
            at  = cyc;
            break;
         end
      end
      chk("ack_seen", 32'(at >= 0), 32'd1);
   endtask

   task automatic wait_rsp(input logic is_read, input int rdy_dly, input logic [15:0] rd,
                           output int at, output logic prev_st);
      at = -1;
      prev_st = 1'b0;
      for (int i = 0; i < 700; i++) begin
         data_rdy = is_read && (i == rdy_dly);
         rd_data  = rd;
         prev_st  = mdio_start;
         tick();
         data_rdy = 1'b0;
         if (rsp0_valid | rsp1_valid) begin
            at = cyc;
            break;
         end
      end
      chk("rsp_seen", 32'(at >= 0), 32'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [1:0] who;
      int         t_ack, t_rsp;
      logic       prev_st;
      req0 = v.r0;
      req1 = v.r1;
      req0_data = v.d;
      req1_data = v.d;
      rises = 0;
      wait_ack(who, t_ack);
      chk($sformatf("v%0d_ack", idx), 32'(who), 32'(v.exp_ack));
      chk($sformatf("v%0d_start", idx), 32'(mdio_start), 32'(v.exp_start));
      chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
      if (v.exp_start) chk($sformatf("v%0d_tdata", idx), t_data, v.d);
      req0 = 1'b0;
      req1 = 1'b0;
      mdc_en = v.exp_start;
      wait_rsp(v.is_read, v.rdy_dly, v.rd, t_rsp, prev_st);
      chk($sformatf("v%0d_rspv", idx), 32'({rsp1_valid, rsp0_valid}), 32'(v.exp_ack));
      chk($sformatf("v%0d_err0", idx), 32'(rsp0_err), 32'(v.exp_ack[0] & v.exp_err));
      chk($sformatf("v%0d_err1", idx), 32'(rsp1_err), 32'(v.exp_ack[1] & v.exp_err));
      chk($sformatf("v%0d_data0", idx), 32'(rsp0_data), 32'(v.exp_ack[0] ? v.exp_data : 16'h0000));
      chk($sformatf("v%0d_data1", idx), 32'(rsp1_data), 32'(v.exp_ack[1] ? v.exp_data : 16'h0000));
      chk($sformatf("v%0d_start_before", idx), 32'(prev_st), 32'(v.exp_start));
      chk($sformatf("v%0d_start_drop", idx), 32'(mdio_start), 32'd0);
      if (v.exp_lat > 0) chk($sformatf("v%0d_lat", idx), 32'(t_rsp - t_ack), 32'(v.exp_lat));
      if (v.exp_start && !v.is_read) chk($sformatf("v%0d_rises", idx), 32'(rises_seen), 32'd32);
      mdc_en = 1'b0;
      tick();
      chk($sformatf("v%0d_rsp_clear", idx),
          {rsp1_data, rsp0_data}, 32'h0000_0000);
      chk($sformatf("v%0d_flags_clear", idx),
          32'({rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}), 32'd0);
      chk($sformatf("v%0d_busy_hold", idx), 32'(busy), 32'd1);
      tick();
      chk($sformatf("v%0d_busy_low", idx), 32'(busy), 32'd0);
   endtask

   vec_t       vecs [7];
   logic [1:0] order [3];
   logic [1:0] who;
   int         t_ack, t_rsp, seen;
   logic       prev_st;

   initial begin
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; req0_data = 32'h0; req1_data = 32'h0;
      mdc = 1'b0; data_rdy = 1'b0; rd_data = 16'h0;
      t_req0 = 1'b0; t_req1 = 1'b0; t_rdy = 1'b0;
      t_req0_data = 32'h0; t_req1_data = 32'h0;

      //          r0    r1    frame         rd    dly  rd_data   ack    st    err   data      lat
      vecs[0] = '{1'b1, 1'b0, 32'h5002_ABCD, 1'b0, -1, 16'h0000, 2'b01, 1'b1, 1'b0, 16'h0000, 0};
      vecs[1] = '{1'b0, 1'b1, 32'h6002_0000, 1'b1, 5, 16'h1234, 2'b10, 1'b1, 1'b0, 16'h1234, 6};
      vecs[2] = '{1'b1, 1'b0, 32'h1002_ABCD, 1'b0, -1, 16'h0000, 2'b01, 1'b0, 1'b1, 16'hFFFF, 1};
      vecs[3] = '{1'b0, 1'b1, 32'h7002_0000, 1'b0, -1, 16'h0000, 2'b10, 1'b0, 1'b1, 16'hFFFF, 1};
      vecs[4] = '{1'b1, 1'b0, 32'h6A5A_0000, 1'b1, 0, 16'hBEEF, 2'b01, 1'b1, 1'b0, 16'hBEEF, 1};
      vecs[5] = '{1'b0, 1'b1, 32'h5FFF_FFFF, 1'b0, -1, 16'h0000, 2'b10, 1'b1, 1'b0, 16'h0000, 0};
      // 32 MDC rises pass long before DATA_RDY; the read must still wait for it.
      vecs[6] = '{1'b0, 1'b1, 32'h6123_0000, 1'b1, 150, 16'hA5A5, 2'b10, 1'b1, 1'b0, 16'hA5A5, 151};
      order[0] = 2'b01;
      order[1] = 2'b10;
      order[2] = 2'b01;

      // Reset state
      tick(); tick(); tick();
      chk("reset_flags", 32'({ack0, ack1, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mdio_start, busy}), 32'd0);
      chk("reset_tdata", t_data, 32'h0);
      chk("reset_rspdata", {rsp1_data, rsp0_data}, 32'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Contention: both requests held for three transactions, order 0,1,0,
      // next ACK exactly 3 edges after each completion.
      req0 = 1'b1; req1 = 1'b1;
      req0_data = 32'h6002_0000;
      req1_data = 32'h6042_0000;
      t_rsp = 0;
      for (int n = 0; n < 3; n++) begin
         wait_ack(who, t_ack);
         chk($sformatf("cont%0d_ack", n), 32'(who), 32'(order[n]));
         chk($sformatf("cont%0d_tdata", n), t_data, order[n][1] ? req1_data : req0_data);
         if (n > 0) chk($sformatf("cont%0d_spacing", n), 32'(t_ack - t_rsp), 32'd3);
         if (n == 2) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         wait_rsp(1'b1, 2, 16'h0F00 + 16'(n), t_rsp, prev_st);
         chk($sformatf("cont%0d_rspv", n), 32'({rsp1_valid, rsp0_valid}), 32'(order[n]));
         chk($sformatf("cont%0d_data", n), 32'(order[n][1] ? rsp1_data : rsp0_data), 32'(16'h0F00 + 16'(n)));
      end
      tick(); tick();

      // Reset in the middle of a read: no response, pointer back to requester 0.
      req0 = 1'b1; req0_data = 32'h6003_0000;
      rises = 0;
      wait_ack(who, t_ack);
      req0 = 1'b0;
      mdc_en = 1'b1;
      for (int i = 0; i < 200 && rises < 10; i++) tick();
      chk("rst_mid_running", 32'(mdio_start), 32'd1);
      reset = 1'b1;
      tick();
      chk("rst_mid_flags", 32'({ack0, ack1, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mdio_start, busy}), 32'd0);
      chk("rst_mid_tdata", t_data, 32'h0);
      reset = 1'b0;
      mdc_en = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp0_valid | rsp1_valid) seen++;
      end
      chk("rst_mid_no_rsp", 32'(seen), 32'd0);
      req0 = 1'b1; req1 = 1'b1;
      req0_data = 32'h6004_0000; req1_data = 32'h6044_0000;
      wait_ack(who, t_ack);
      chk("rst_tie_ack", 32'(who), 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      wait_rsp(1'b1, 3, 16'h7E57, t_rsp, prev_st);
      chk("rst_tie_rsp", {15'd0, rsp1_valid, rsp0_data}, 32'h0000_7E57);
      tick(); tick();

      // Timeout on the TIMEOUT=64 instance: the error response lands 64 edges
      // after the ACK edge (the 65th cycle counting the ACK cycle as the first).
      t_req0 = 1'b1; t_req0_data = 32'h6002_0000;
      t_ack = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (t_ack0) begin t_ack = cyc; break; end
      end
      chk("to_ack_seen", 32'(t_ack >= 0), 32'd1);
      t_req0 = 1'b0;
      t_rsp = -1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (t_rsp0_valid) begin t_rsp = cyc; break; end
      end
      chk("to_lat", 32'(t_rsp - t_ack), 32'd64);
      chk("to_err", 32'(t_rsp0_err), 32'd1);
      chk("to_data", 32'(t_rsp0_data), 32'h0000_FFFF);
      chk("to_start", 32'(t_start), 32'd0);
      tick(); tick();
      t_req0 = 1'b1; t_req0_data = 32'h6005_0000;
      t_ack = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (t_ack0) begin t_ack = cyc; break; end
      end
      chk("to_next_ack", 32'(t_ack >= 0), 32'd1);
      t_req0 = 1'b0;
      rd_data = 16'h5A5A;
      t_rsp = -1;
      for (int i = 0; i < 100; i++) begin
         t_rdy = (i == 3);
         tick();
         t_rdy = 1'b0;
         if (t_rsp0_valid) begin t_rsp = cyc; break; end
      end
      chk("to_next_lat", 32'(t_rsp - t_ack), 32'd4);
      chk("to_next_rsp", {15'd0, t_rsp0_err, t_rsp0_data}, 32'h0000_5A5A);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
